// File: rtl/change_dispenser_fsm.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser_fsm
// Purpose  : Pays out requested change one coin at a time (dimes first, then
//            nickels) and tracks hopper inventory with refill and short-change.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser_fsm #(
    parameter int AMT_W       = 6,
    parameter int CNT_W       = 8,
    parameter int NICKEL_INIT = 0,
    parameter int DIME_INIT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             out_valid,
    output logic             out_is_dime,
    input  logic             out_ack,
    input  logic             refill_nickel,
    input  logic             refill_dime,
    output logic             done,
    output logic             short,
    output logic [CNT_W-1:0] nickel_cnt,
    output logic [CNT_W-1:0] dime_cnt,
    output logic             exact_change_only
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SELECT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_nickel_init = CNT_W'(NICKEL_INIT);
    localparam logic [CNT_W-1:0] c_dime_init   = CNT_W'(DIME_INIT);
    localparam logic [AMT_W-1:0] c_amt_one     = AMT_W'(1);
    localparam logic [AMT_W-1:0] c_amt_two     = AMT_W'(2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AMT_W-1:0] r_remaining;
    logic [AMT_W-1:0] w_remaining_nxt;
    logic             r_short;
    logic             w_short_nxt;
    logic             r_is_dime;
    logic             w_is_dime_nxt;
    logic [CNT_W-1:0] r_nickel_cnt;
    logic [CNT_W-1:0] r_dime_cnt;
    logic             w_use_nickel;
    logic             w_use_dime;

    assign w_use_dime   = (r_state == S_DISPENSE) && out_ack && r_is_dime;
    assign w_use_nickel = (r_state == S_DISPENSE) && out_ack && !r_is_dime;

    // Refill and consume cancel; a lone refill at full scale is dropped.
    function automatic logic [CNT_W-1:0] cnt_update(
        input logic [CNT_W-1:0] cnt,
        input logic             refill,
        input logic             consume
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (refill && !consume && (cnt != c_cnt_max))
            nxt = cnt + 1'b1;
        else if (!refill && consume)
            nxt = cnt - 1'b1;
        return nxt;
    endfunction

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_short_nxt     = r_short;
        w_is_dime_nxt   = r_is_dime;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_remaining_nxt = req_amount;
                    w_short_nxt     = 1'b0;
                    w_state_nxt     = (req_amount == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if ((r_remaining >= c_amt_two) && (r_dime_cnt != '0)) begin
                    w_is_dime_nxt = 1'b1;
                    w_state_nxt   = S_DISPENSE;
                end else if ((r_remaining >= c_amt_one) && (r_nickel_cnt != '0)) begin
                    w_is_dime_nxt = 1'b0;
                    w_state_nxt   = S_DISPENSE;
                end else begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DISPENSE: begin
                if (out_ack) begin
                    w_remaining_nxt = r_remaining - (r_is_dime ? c_amt_two : c_amt_one);
                    w_state_nxt     = (w_remaining_nxt == '0) ? S_DONE : S_SELECT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_short      <= 1'b0;
            r_is_dime    <= 1'b0;
            r_nickel_cnt <= c_nickel_init;
            r_dime_cnt   <= c_dime_init;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_short      <= w_short_nxt;
            r_is_dime    <= w_is_dime_nxt;
            r_nickel_cnt <= cnt_update(r_nickel_cnt, refill_nickel, w_use_nickel);
            r_dime_cnt   <= cnt_update(r_dime_cnt, refill_dime, w_use_dime);
        end
    end

    assign req_ready         = (r_state == S_IDLE);
    assign out_valid         = (r_state == S_DISPENSE);
    assign out_is_dime       = (r_state == S_DISPENSE) && r_is_dime;
    assign done              = (r_state == S_DONE);
    assign short             = (r_state == S_DONE) && r_short;
    assign nickel_cnt        = r_nickel_cnt;
    assign dime_cnt          = r_dime_cnt;
    assign exact_change_only = (r_nickel_cnt == '0);

endmodule
`default_nettype wire
